// File: rtl/lb_pkg.sv
// Shared definitions for the multi-tap line buffer: mode encoding, config field
// layout and config register addresses.
package lb_pkg;

  typedef enum logic [1:0] {
    LB_MODE_LINEBUF = 2'd0
  } lb_mode_e;

  localparam int LB_MODE_LSB  = 0;
  localparam int LB_MODE_W    = 2;
  localparam int LB_EN_BIT    = 2;
  localparam int LB_DEPTH_LSB = 3;
  localparam int LB_DEPTH_W   = 13;
  localparam int LB_CFG_W     = 16;

  localparam logic [31:0] LB_CFG_ADDR = 32'd0;
  localparam logic [31:0] LB_CNT_ADDR = 32'd1;

endpackage

// File: rtl/lb_line_ram.sv
// One circular line of the buffer: asynchronous read of the current slot, so the
// value being evicted is available before the write lands at the same edge.
module lb_line_ram
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 1024,
  parameter int AW         = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MAX_DEPTH];

  assign rdata = mem_r[addr];

  // Line storage write; contents deliberately survive flush and reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_mt.sv
// Multi-tap line buffer: NUM_TAPS cascaded circular lines give vertically aligned taps.
// Optional macro LB_PUSH_COUNT_EN adds a 32-bit push counter readable at config address 1.
module line_buffer_mt
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 1024,
  parameter int NUM_TAPS   = 2,
  parameter int CNT_WIDTH  = $clog2(MAX_DEPTH*NUM_TAPS+1)
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           config_en,
  input  logic                           config_read,
  input  logic [31:0]                    config_addr,
  input  logic [31:0]                    config_data,
  output logic [31:0]                    read_data,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           wen_in,
  input  logic                           flush,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_TAPS-1:0]            valid_out
);

  localparam int          AW          = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [31:0] MAX_DEPTH_L = 32'(MAX_DEPTH);

  logic [LB_CFG_W-1:0]           cfg_r;
  logic [LB_DEPTH_W-1:0]         depth_raw_s;
  logic [CNT_WIDTH-1:0]          depth_s;
  logic [CNT_WIDTH-1:0]          full_s;
  logic [CNT_WIDTH-1:0]          fill_r;
  logic [CNT_WIDTH-1:0]          fill_nxt_s;
  logic [CNT_WIDTH-1:0]          thr_s [NUM_TAPS];
  logic [AW-1:0]                 wp_r;
  logic [AW-1:0]                 wp_nxt_s;
  logic                          active_s;
  logic                          cfg_wr_s;
  logic                          push_s;
  logic [NUM_TAPS-1:0]           vld_r;
  logic [NUM_TAPS-1:0]           vld_nxt_s;
  logic [NUM_TAPS*DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0]         rd_s [NUM_TAPS];
  logic [DATA_WIDTH-1:0]         wd_s [NUM_TAPS];
  logic [31:0]                   rd_r;
  logic [31:0]                   rd_nxt_s;
  logic [31:0]                   cnt_s;
  logic                          unused_cfg_s;

  assign depth_raw_s  = cfg_r[LB_DEPTH_LSB +: LB_DEPTH_W];
  assign cfg_wr_s     = config_en && (config_addr == LB_CFG_ADDR);
  assign unused_cfg_s = ^config_data[31:LB_CFG_W];
  // A config write restarts the stream, so it also blocks any push in that cycle.
  assign push_s       = clk_en && active_s && wen_in && !flush && !reset && !cfg_wr_s;

  // Effective depth (clamped) and whether the block is running at all.
  always_comb begin
    depth_s  = {CNT_WIDTH{1'b0}};
    active_s = 1'b0;
    if (32'(depth_raw_s) > MAX_DEPTH_L) begin
      depth_s = MAX_DEPTH_L[CNT_WIDTH-1:0];
    end else begin
      depth_s = CNT_WIDTH'(depth_raw_s);
    end
    if ((cfg_r[LB_MODE_LSB +: LB_MODE_W] == LB_MODE_LINEBUF) && cfg_r[LB_EN_BIT] &&
        (depth_raw_s != {LB_DEPTH_W{1'b0}})) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    full_s = CNT_WIDTH'(32'(depth_s) * NUM_TAPS);
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign thr_s[k] = CNT_WIDTH'(32'(depth_s) * (k + 1));
    if (k == 0) begin : g_first
      assign wd_s[k] = data_in;
    end else begin : g_next
      assign wd_s[k] = rd_s[k-1];
    end
    lb_line_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .AW        (AW)
    ) u_line (
      .clk  (clk_in),
      .we   (push_s),
      .addr (wp_r),
      .wdata(wd_s[k]),
      .rdata(rd_s[k])
    );
  end

  // Next pointer, saturating fill and per-tap valid for a push this cycle.
  always_comb begin
    wp_nxt_s   = wp_r;
    fill_nxt_s = fill_r;
    vld_nxt_s  = {NUM_TAPS{1'b0}};
    if (CNT_WIDTH'(wp_r) == (depth_s - CNT_WIDTH'(1'b1))) begin
      wp_nxt_s = {AW{1'b0}};
    end else begin
      wp_nxt_s = wp_r + AW'(1'b1);
    end
    if (fill_r >= full_s) begin
      fill_nxt_s = full_s;
    end else begin
      fill_nxt_s = fill_r + CNT_WIDTH'(1'b1);
    end
    for (int k = 0; k < NUM_TAPS; k++) begin
      vld_nxt_s[k] = (fill_r >= thr_s[k]);
    end
  end

  // Datapath state: pointer, fill, registered evicted taps and their valids.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wp_r   <= {AW{1'b0}};
      fill_r <= {CNT_WIDTH{1'b0}};
      vld_r  <= {NUM_TAPS{1'b0}};
      data_r <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
    end else if (cfg_wr_s) begin
      wp_r   <= {AW{1'b0}};
      fill_r <= {CNT_WIDTH{1'b0}};
      vld_r  <= {NUM_TAPS{1'b0}};
    end else if (clk_en) begin
      if (flush) begin
        wp_r   <= {AW{1'b0}};
        fill_r <= {CNT_WIDTH{1'b0}};
        vld_r  <= {NUM_TAPS{1'b0}};
      end else if (push_s) begin
        wp_r   <= wp_nxt_s;
        fill_r <= fill_nxt_s;
        vld_r  <= vld_nxt_s;
        for (int k = 0; k < NUM_TAPS; k++) begin
          data_r[k*DATA_WIDTH +: DATA_WIDTH] <= rd_s[k];
        end
      end else begin
        vld_r <= {NUM_TAPS{1'b0}};
      end
    end
  end

  // Config register 0; writes are independent of clk_en.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg_r <= {LB_CFG_W{1'b0}};
    end else if (cfg_wr_s) begin
      cfg_r <= config_data[LB_CFG_W-1:0];
    end
  end

`ifdef LB_PUSH_COUNT_EN
  logic [31:0] cnt_r;

  // Wrapping push counter, restarted together with the stream.
  always_ff @(posedge clk_in) begin
    if (reset || cfg_wr_s || (clk_en && flush)) begin
      cnt_r <= 32'd0;
    end else if (push_s) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign cnt_s = cnt_r;
`else
  assign cnt_s = 32'd0;
`endif

  // Read-back source selection.
  always_comb begin
    rd_nxt_s = 32'd0;
    case (config_addr)
      LB_CFG_ADDR: rd_nxt_s = {{(32-LB_CFG_W){1'b0}}, cfg_r};
      LB_CNT_ADDR: rd_nxt_s = cnt_s;
      default:     rd_nxt_s = 32'd0;
    endcase
  end

  // Registered read-back, held between read strobes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_r <= 32'd0;
    end else if (config_read) begin
      rd_r <= rd_nxt_s;
    end
  end

  assign read_data = rd_r;
  assign data_out  = data_r;
  assign valid_out = vld_r;

endmodule

// File: tb/tb_line_buffer_mt.sv
// Self-checking bench for line_buffer_mt: every cycle is compared against a
// push-history model (tap k = value pushed depth*(k+1) pushes earlier).
module tb_line_buffer_mt;

  localparam int DW = 16;
  localparam int MD = 1024;
  localparam int NT = 2;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b1;
  logic          config_en = 1'b0;
  logic          config_read = 1'b0;
  logic [31:0]   config_addr = 32'd0;
  logic [31:0]   config_data = 32'd0;
  logic [31:0]   read_data;
  logic [DW-1:0] data_in = '0;
  logic          wen_in = 1'b0;
  logic          flush = 1'b0;
  logic [NT*DW-1:0] data_out;
  logic [NT-1:0] valid_out;

  int tests_run = 0;
  int tests_failed = 0;

  // behavioural model state
  logic [15:0] m_cfg = 16'd0;
  int          m_hist[$];
  logic [NT-1:0] m_valid = '0;
  int          m_data[NT];
  bit          m_known[NT];
  logic [31:0] m_rd = 32'd0;
  logic [31:0] m_cnt = 32'd0;

  line_buffer_mt #(.DATA_WIDTH(DW), .MAX_DEPTH(MD), .NUM_TAPS(NT)) dut (
    .clk_in(clk_in), .reset(reset), .clk_en(clk_en), .config_en(config_en),
    .config_read(config_read), .config_addr(config_addr), .config_data(config_data),
    .read_data(read_data), .data_in(data_in), .wen_in(wen_in), .flush(flush),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_depth();
    int d;
    d = int'(m_cfg[15:3]);
    if (m_cfg[1:0] != 2'd0 || !m_cfg[2] || d == 0) return 0;
    return (d > MD) ? MD : d;
  endfunction

  task automatic tick();
    int dep;
    int n;
    @(posedge clk_in);
    if (reset) begin
      m_cfg = 16'd0;
      m_hist.delete();
      m_valid = '0;
      m_rd = 32'd0;
      m_cnt = 32'd0;
      for (int k = 0; k < NT; k++) begin
        m_data[k] = 0;
        m_known[k] = 1'b1;
      end
    end else begin
      dep = eff_depth();
      if (config_read) begin
        if (config_addr == 32'd0) m_rd = {16'd0, m_cfg};
`ifdef LB_PUSH_COUNT_EN
        else if (config_addr == 32'd1) m_rd = m_cnt;
`endif
        else m_rd = 32'd0;
      end
      if (config_en && config_addr == 32'd0) begin
        m_cfg = config_data[15:0];
        m_hist.delete();
        m_valid = '0;
        m_cnt = 32'd0;
      end else if (clk_en) begin
        if (flush) begin
          m_hist.delete();
          m_valid = '0;
          m_cnt = 32'd0;
        end else if (wen_in && dep != 0) begin
          n = m_hist.size();
          for (int k = 0; k < NT; k++) begin
            if (n >= dep * (k + 1)) begin
              m_valid[k] = 1'b1;
              m_data[k] = m_hist[n - dep * (k + 1)];
              m_known[k] = 1'b1;
            end else begin
              m_valid[k] = 1'b0;
              m_known[k] = 1'b0;
            end
          end
          m_hist.push_back(int'(data_in));
          m_cnt = m_cnt + 32'd1;
        end else begin
          m_valid = '0;
        end
      end
    end
    #1;
    check_eq("valid", 32'(valid_out), 32'(m_valid));
    for (int k = 0; k < NT; k++) begin
      if (m_known[k]) check_eq($sformatf("tap%0d", k), 32'(data_out[k*DW +: DW]), 32'(m_data[k][DW-1:0]));
    end
    check_eq("read_data", read_data, m_rd);
  endtask

  task automatic cyc(input bit w, input logic [DW-1:0] d);
    wen_in = w;
    data_in = d;
    tick();
    wen_in = 1'b0;
  endtask

  task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
    config_en = 1'b1;
    config_addr = addr;
    config_data = data;
    tick();
    config_en = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] addr);
    config_read = 1'b1;
    config_addr = addr;
    tick();
    config_read = 1'b0;
  endtask

  initial begin
    // reset
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_data", data_out, 32'd0);
    reset = 1'b0;

    // depth 10, sequential pushes
    cfg_wr(32'd0, 32'h54);
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b1, DW'(i));
      if (i == 10) check_eq("a_tap0_not_yet", 32'(valid_out), 32'd0);
      if (i == 11) check_eq("a_tap0_first", {15'd0, valid_out[0], data_out[15:0]}, {15'd0, 1'b1, 16'd1});
      if (i == 20) check_eq("a_tap1_not_yet", 32'(valid_out[1]), 32'd0);
      if (i == 21) check_eq("a_tap1_first", {15'd0, valid_out[1], data_out[31:16]}, {15'd0, 1'b1, 16'd1});
      if (i == 30) check_eq("a_taps_30", data_out, {16'd10, 16'd20});
    end
    cfg_rd(32'd0);
    check_eq("a_cfg_rd0", read_data, 32'h54);
    cfg_rd(32'd5);
    cfg_rd(32'd1);

    // random wen, random data
    for (int i = 0; i < 200; i++) begin
      cyc(bit'($urandom_range(0, 1)), DW'($urandom));
    end

    // flush held 3 cycles with wen_in high
    cfg_wr(32'd0, 32'h54);
    for (int i = 1; i <= 40; i++) cyc(1'b1, DW'(500 + i));
    flush = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(900 + i));
    flush = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, DW'(1000 + i));
      if (i == 10) check_eq("c_post_flush_10", 32'(valid_out), 32'd0);
      if (i == 11) check_eq("c_post_flush_11", {15'd0, valid_out[0], data_out[15:0]}, {15'd0, 1'b1, 16'd1001});
    end

    // clock enable freeze with read-back and ignored flush
    for (int i = 1; i <= 20; i++) cyc(1'b1, DW'(2000 + i));
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        config_read = 1'b1;
        config_addr = 32'd0;
        flush = 1'b1;
      end
      cyc(1'b1, DW'(3000 + i));
      if (i == 2) check_eq("d_freeze_rd", read_data, 32'h54);
      config_read = 1'b0;
      flush = 1'b0;
    end
    clk_en = 1'b1;
    for (int i = 1; i <= 10; i++) cyc(1'b1, DW'(4000 + i));

    // disabled configurations
    cfg_wr(32'd0, 32'h4);
    for (int i = 1; i <= 30; i++) cyc(1'b1, DW'(i));
    check_eq("e_depth0", 32'(valid_out), 32'd0);
    cfg_wr(32'd0, 32'h55);
    for (int i = 1; i <= 30; i++) cyc(1'b1, DW'(i));

    // depth 2000 clamps to MAX_DEPTH
    cfg_wr(32'd0, (32'd2000 << 3) | 32'd4);
    for (int i = 1; i <= 1030; i++) begin
      cyc(1'b1, DW'(i));
      if (i == 1024) check_eq("f_clamp_1024", 32'(valid_out), 32'd0);
      if (i == 1025) check_eq("f_clamp_1025", {15'd0, valid_out[0], data_out[15:0]}, {15'd0, 1'b1, 16'd1});
    end

    // reset mid-stream
    cfg_wr(32'd0, 32'h54);
    for (int i = 1; i <= 15; i++) cyc(1'b1, DW'(i));
    reset = 1'b1;
    cyc(1'b1, DW'(77));
    reset = 1'b0;
    check_eq("g_rst_data", data_out, 32'd0);
    check_eq("g_rst_valid", 32'(valid_out), 32'd0);
    cfg_rd(32'd0);
    check_eq("g_rst_cfg", read_data, 32'd0);
    for (int i = 1; i <= 25; i++) cyc(1'b1, DW'(i));
    cfg_wr(32'd0, 32'h54);
    for (int i = 1; i <= 25; i++) cyc(1'b1, DW'(100 + i));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
